// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares a single word-addressed memory port between the
// instruction-fetch requester (IF) and the load/store requester (D). At most one
// access is issued per cycle; read responses are steered back to their owner
// through a fixed-latency tracking pipeline, and stale fetches are discarded
// on redirect by a 1-bit epoch.
module mem_port_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_LATENCY   = 1,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_req,
  input  logic [ADDRESS_WIDTH-1:0] if_addr,
  output logic                     if_gnt,
  output logic                     if_rvalid,
  output logic [DATA_WIDTH-1:0]    if_rdata,
  input  logic                     if_flush,
  output logic                     if_misalign,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDRESS_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0]    d_wdata,
  input  logic [3:0]               d_be,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [DATA_WIDTH-1:0]    d_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [3:0]               mem_be,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  localparam int             CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);
  localparam int             LAST  = MEM_LATENCY - 1;

  // Arbitration state
  logic [CW-1:0]            starve_q, starve_d;
  logic                     epoch_q, epoch_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;

  // In-flight tracking pipeline: index 0 is the newest access, LAST the oldest
  logic [MEM_LATENCY-1:0]   pv_q, pv_d;   // entry holds a read
  logic [MEM_LATENCY-1:0]   po_q, po_d;   // owner: 1 = D, 0 = IF
  logic [MEM_LATENCY-1:0]   pe_q, pe_d;   // epoch at issue time

  logic if_prio, if_wins;

  // D address low bits select bytes inside a word and play no part in the word index
  logic d_addr_lsb_unused;
  assign d_addr_lsb_unused = ^d_addr[1:0];

  // Grant selection, memory-port drive and starvation counter update
  always_comb begin
    if_prio     = (starve_q == LIMIT);
    if_wins     = !rst && if_req && (if_prio || !d_req);
    if_misalign = if_wins && (if_addr[1:0] != 2'b00);
    if_gnt      = if_wins && !if_misalign;
    // A misaligned fetch gives up the port, so D can still use this cycle
    d_gnt       = !rst && d_req && !if_gnt;

    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    mem_we      = 1'b0;
    mem_be      = 4'h0;
    if (if_gnt) begin
      mem_addr_d = {2'b00, if_addr[ADDRESS_WIDTH-1:2]};
      mem_be     = 4'hF;
    end else if (d_gnt) begin
      mem_addr_d = {2'b00, d_addr[ADDRESS_WIDTH-1:2]};
      wdata_d    = d_wdata;
      mem_we     = d_we;
      mem_be     = d_we ? d_be : 4'hF;
    end
    mem_req   = if_gnt || d_gnt;
    mem_addr  = mem_addr_d;
    mem_wdata = wdata_d;

    starve_d = starve_q;
    if (!if_req || if_gnt || if_misalign) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + CW'(1);
    end

    epoch_d = epoch_q ^ if_flush;
  end

  // Shift the tracking pipeline one stage and push this cycle's access
  always_comb begin
    pv_d = pv_q;
    po_d = po_q;
    pe_d = pe_q;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      po_d[i] = po_q[i-1];
      pe_d[i] = pe_q[i-1];
    end
    pv_d[0] = if_gnt || (d_gnt && !d_we);
    po_d[0] = d_gnt;
    pe_d[0] = epoch_q;
  end

  // State registers; reset empties the pipeline so earlier reads never return
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q   <= '0;
      epoch_q    <= 1'b0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      pv_q       <= '0;
      po_q       <= '0;
      pe_q       <= '0;
    end else begin
      starve_q   <= starve_d;
      epoch_q    <= epoch_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      pv_q       <= pv_d;
      po_q       <= po_d;
      pe_q       <= pe_d;
    end
  end

  // Steer the oldest in-flight read back to its owner; fetches from an old epoch are dropped
  assign if_rvalid = !rst && pv_q[LAST] && !po_q[LAST] && (pe_q[LAST] == epoch_q);
  assign d_rvalid  = !rst && pv_q[LAST] && po_q[LAST];
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (MEM_LATENCY 1, 2, 3)
// share the same request stimulus and a behavioural memory.
module tb_mem_port_arbiter;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req, if_flush, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic [3:0]  d_be;

  logic [NI-1:0] if_gnt_w, if_rvalid_w, if_misalign_w, d_gnt_w, d_rvalid_w, mem_req_w, mem_we_w;
  logic [31:0]   if_rdata_w  [NI];
  logic [31:0]   d_rdata_w   [NI];
  logic [31:0]   mem_addr_w  [NI];
  logic [31:0]   mem_wdata_w [NI];
  logic [3:0]    mem_be_w    [NI];
  logic [31:0]   rdpipe      [NI];
  logic [31:0]   mem         [64];

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      mem_port_arbiter #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(gi + 1), .STARVE_LIMIT(4)
      ) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_w[gi]),
        .if_rvalid(if_rvalid_w[gi]), .if_rdata(if_rdata_w[gi]),
        .if_flush(if_flush), .if_misalign(if_misalign_w[gi]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt_w[gi]), .d_rvalid(d_rvalid_w[gi]), .d_rdata(d_rdata_w[gi]),
        .mem_req(mem_req_w[gi]), .mem_we(mem_we_w[gi]), .mem_addr(mem_addr_w[gi]),
        .mem_wdata(mem_wdata_w[gi]), .mem_be(mem_be_w[gi]), .mem_rdata(rdpipe[gi])
      );
    end
  endgenerate

  // Behavioural memory: words preloaded with 0x1000_0000+index, read data delayed k+1 cycles
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
      for (int k = 0; k < NI; k++) rdpipe[k] <= 32'h0;
    end else begin
      if (mem_req_w[0] && mem_we_w[0]) begin
        for (int b = 0; b < 4; b++)
          if (mem_be_w[0][b]) mem[mem_addr_w[0][5:0]][8*b +: 8] <= mem_wdata_w[0][8*b +: 8];
      end
      rdpipe[0] <= (mem_req_w[0] && !mem_we_w[0]) ? mem[mem_addr_w[0][5:0]] : 32'h0;
      for (int k = 1; k < NI; k++) rdpipe[k] <= rdpipe[k-1];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; if_req = 0; if_flush = 0; if_addr = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset gnt/req/we[%0d]", k),
            {if_gnt_w[k], d_gnt_w[k], mem_req_w[k], mem_we_w[k], if_misalign_w[k]}, 32'h0);
      check($sformatf("reset rvalid[%0d]", k), {if_rvalid_w[k], d_rvalid_w[k]}, 32'h0);
      check($sformatf("reset mem_be[%0d]", k), mem_be_w[k], 32'h0);
      check($sformatf("reset mem_addr[%0d]", k), mem_addr_w[k], 32'h0);
    end

    // Contention: both request every cycle -> 4 D grants then 1 IF grant, repeating
    tick();
    if_req = 1; if_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'h10;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      #1;
      check($sformatf("contend if_gnt c%0d", c), if_gnt_w[0], (c % 5 == 4));
      check($sformatf("contend d_gnt c%0d", c), d_gnt_w[0], (c % 5 != 4));
      check($sformatf("contend mem_addr c%0d", c), mem_addr_w[0], (c % 5 == 4) ? 32'd2 : 32'd4);
      for (int k = 0; k < NI; k++) begin
        if (c >= k + 1) begin
          if ((c - k - 1) % 5 == 4) begin
            check($sformatf("contend if_rvalid[%0d] c%0d", k, c), {if_rvalid_w[k], d_rvalid_w[k]}, 32'h2);
            check($sformatf("contend if_rdata[%0d] c%0d", k, c), if_rdata_w[k], 32'h1000_0002);
          end else begin
            check($sformatf("contend d_rvalid[%0d] c%0d", k, c), {if_rvalid_w[k], d_rvalid_w[k]}, 32'h1);
            check($sformatf("contend d_rdata[%0d] c%0d", k, c), d_rdata_w[k], 32'h1000_0004);
          end
        end else begin
          check($sformatf("contend idle rvalid[%0d] c%0d", k, c), {if_rvalid_w[k], d_rvalid_w[k]}, 32'h0);
        end
      end
    end
    tick();
    if_req = 0; d_req = 0;
    repeat (4) tick();

    // Write then read back through byte enables
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    #1;
    check("wr d_gnt", d_gnt_w[0], 32'h1);
    check("wr mem_we", mem_we_w[0], 32'h1);
    check("wr mem_addr", mem_addr_w[0], 32'h8);
    check("wr mem_be", mem_be_w[0], 32'h3);
    check("wr mem_wdata", mem_wdata_w[0], 32'hDEAD_BEEF);
    tick();
    d_we = 0; d_be = 0;
    #1;
    check("rd mem_we", mem_we_w[0], 32'h0);
    check("rd mem_be", mem_be_w[0], 32'hF);
    check("wr no d_rvalid", d_rvalid_w[0], 32'h0);
    tick();
    d_req = 0;
    #1;
    check("rd d_rvalid", d_rvalid_w[0], 32'h1);
    check("rd d_rdata", d_rdata_w[0], 32'h1000_BEEF);
    check("idle mem_req", mem_req_w[0], 32'h0);
    check("idle mem_addr hold", mem_addr_w[0], 32'h8);
    check("idle mem_be", mem_be_w[0], 32'h0);
    check("idle mem_wdata hold", mem_wdata_w[0], 32'hDEAD_BEEF);
    repeat (2) tick();

    // Flush: three back-to-back fetches, flush in the third grant cycle
    if_req = 1; if_addr = 32'h0;
    #1;
    check("flush f0 if_gnt", if_gnt_w[2], 32'h1);
    tick();
    if_addr = 32'h4;
    #1;
    check("flush f1 if_gnt", if_gnt_w[2], 32'h1);
    tick();
    if_addr = 32'h8; if_flush = 1;
    #1;
    check("flush f2 if_gnt", if_gnt_w[2], 32'h1);
    check("flush L1 pre-edge rvalid", if_rvalid_w[0], 32'h1);
    check("flush L1 pre-edge rdata", if_rdata_w[0], 32'h1000_0001);
    check("flush L2 pre-edge rvalid", if_rvalid_w[1], 32'h1);
    check("flush L2 pre-edge rdata", if_rdata_w[1], 32'h1000_0000);
    tick();
    if_flush = 0; if_addr = 32'h40;
    #1;
    check("flush 0x40 if_gnt", if_gnt_w[2], 32'h1);
    check("flush L1 killed", if_rvalid_w[0], 32'h0);
    check("flush L2 killed", if_rvalid_w[1], 32'h0);
    check("flush L3 killed f0", if_rvalid_w[2], 32'h0);
    tick();
    if_req = 0;
    #1;
    check("flush L3 killed f1", if_rvalid_w[2], 32'h0);
    check("flush L1 0x40 rvalid", if_rvalid_w[0], 32'h1);
    check("flush L1 0x40 rdata", if_rdata_w[0], 32'h1000_0010);
    tick();
    check("flush L3 killed f2", if_rvalid_w[2], 32'h0);
    tick();
    check("flush L3 0x40 rvalid", if_rvalid_w[2], 32'h1);
    check("flush L3 0x40 rdata", if_rdata_w[2], 32'h1000_0010);

    // Misaligned fetch and starvation counter clearing
    tick();
    if_req = 1; if_addr = 32'h6; d_req = 1; d_we = 0; d_addr = 32'h13;
    for (int p = 0; p < 2; p++) begin
      if (p > 0) tick();
      #1;
      check($sformatf("mis pre d_gnt p%0d", p), d_gnt_w[0], 32'h1);
      check($sformatf("mis pre if_misalign p%0d", p), if_misalign_w[0], 32'h0);
    end
    tick();
    d_req = 0;
    #1;
    check("mis alone if_misalign", if_misalign_w[0], 32'h1);
    check("mis alone mem_req", mem_req_w[0], 32'h0);
    check("mis alone gnts", {if_gnt_w[0], d_gnt_w[0]}, 32'h0);
    tick();
    d_req = 1;
    for (int m = 1; m <= 5; m++) begin
      if (m > 1) tick();
      #1;
      check($sformatf("mis m%0d if_misalign", m), if_misalign_w[0], (m == 5));
      check($sformatf("mis m%0d gnts", m), {if_gnt_w[0], d_gnt_w[0]}, 32'h1);
      check($sformatf("mis m%0d mem_addr", m), mem_addr_w[0], 32'h4);
    end
    tick();
    if_req = 0; d_req = 0;
    repeat (4) tick();

    // Reset while a D read is in flight
    d_req = 1; d_we = 0; d_addr = 32'h10;
    #1;
    check("rst d_gnt", d_gnt_w[1], 32'h1);
    tick();
    d_req = 0; rst = 1;
    #1;
    check("rst cycle L1 d_rvalid", d_rvalid_w[0], 32'h0);
    tick();
    rst = 0;
    for (int r = 0; r < 4; r++) begin
      if (r > 0) tick();
      #1;
      for (int k = 0; k < NI; k++) begin
        check($sformatf("post-rst rvalid[%0d] r%0d", k, r), {if_rvalid_w[k], d_rvalid_w[k]}, 32'h0);
        check($sformatf("post-rst port[%0d] r%0d", k, r),
              {if_gnt_w[k], d_gnt_w[k], mem_req_w[k], mem_we_w[k], mem_be_w[k]}, 32'h0);
      end
    end
    check("post-rst mem_addr", mem_addr_w[1], 32'h0);

    // Interleaved owners, one request per cycle alternating IF / D
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c < 6) begin
        if_req = (c % 2 == 0); d_req = (c % 2 == 1);
        if_addr = 32'hC; d_addr = 32'h18; d_we = 0;
      end else begin
        if_req = 0; d_req = 0;
      end
      #1;
      if (c < 6) begin
        check($sformatf("ilv gnt c%0d", c), {if_gnt_w[1], d_gnt_w[1]}, (c % 2 == 0) ? 32'h2 : 32'h1);
      end
      if (c >= 2) begin
        if ((c - 2) % 2 == 0) begin
          check($sformatf("ilv if_rvalid c%0d", c), {if_rvalid_w[1], d_rvalid_w[1]}, 32'h2);
          check($sformatf("ilv if_rdata c%0d", c), if_rdata_w[1], 32'h1000_0003);
        end else begin
          check($sformatf("ilv d_rvalid c%0d", c), {if_rvalid_w[1], d_rvalid_w[1]}, 32'h1);
          check($sformatf("ilv d_rdata c%0d", c), d_rdata_w[1], 32'h1000_0006);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
